// File: rtl/vend_controller.sv
// Vending transaction controller: credit, dispense, change and error codes.
// All outputs are registered so the display can sample them on the falling edge.
module vend_controller #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 5,
    parameter int PRICE2     = 7,
    parameter int MAX_CREDIT = 15,
    parameter int ERR_HOLD   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coin_valid,
    input  logic [1:0]  coin_value,
    input  logic        select_valid,
    input  logic [1:0]  select_id,
    input  logic        cancel,
    input  logic [2:0]  stock_empty,
    output logic [10:0] credit,
    output logic [1:0]  redlight,
    output logic        dispense_valid,
    output logic [1:0]  dispense_id,
    output logic        change_valid,
    output logic [10:0] change_amount,
    output logic        coin_return,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHANGE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int CW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_M1 = CW'(ERR_HOLD - 1);
    localparam logic [4:0] MAXC = 5'(MAX_CREDIT);
    localparam logic [3:0] P0 = 4'(PRICE0);
    localparam logic [3:0] P1 = 4'(PRICE1);
    localparam logic [3:0] P2 = 4'(PRICE2);

    localparam logic [1:0] E_FUNDS = 2'd1;
    localparam logic [1:0] E_STOCK = 2'd2;
    localparam logic [1:0] E_INVAL = 2'd3;

    state_t        state_q, state_d;
    logic [3:0]    cred_q, cred_d;
    logic [1:0]    red_q, red_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dv_q, dv_d;
    logic [1:0]    did_q, did_d;
    logic          cv_q, cv_d;
    logic [3:0]    chg_q, chg_d;
    logic          cret_q, cret_d;
    logic          busy_q, busy_d;

    logic [2:0] coin_amt;
    logic [4:0] coin_sum;
    logic [3:0] price;
    logic       sold_out;
    logic [3:0] remain;

    always_comb begin
        coin_amt = 3'd0;
        case (coin_value)
            2'd0:    coin_amt = 3'd1;
            2'd1:    coin_amt = 3'd2;
            2'd2:    coin_amt = 3'd5;
            default: coin_amt = 3'd0;
        endcase
        price    = P0;
        sold_out = 1'b0;
        case (select_id)
            2'd0: begin price = P0; sold_out = stock_empty[0]; end
            2'd1: begin price = P1; sold_out = stock_empty[1]; end
            2'd2: begin price = P2; sold_out = stock_empty[2]; end
            default: begin price = P0; sold_out = 1'b0; end
        endcase
        coin_sum = {1'b0, cred_q} + {2'b00, coin_amt};
        remain   = cred_q - price;
    end

    always_comb begin
        state_d = state_q;
        cred_d  = cred_q;
        red_d   = red_q;
        cnt_d   = cnt_q;
        dv_d    = 1'b0;
        did_d   = 2'd0;
        cv_d    = 1'b0;
        chg_d   = 4'd0;
        cret_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // cancel > select > coin; a coin that loses is returned
                if (cancel) begin
                    cret_d = coin_valid;
                    if (cred_q != 4'd0)
                        state_d = CHANGE;
                end else if (select_valid) begin
                    cret_d = coin_valid;
                    if (select_id == 2'd3) begin
                        state_d = ERROR;
                        red_d   = E_INVAL;
                        cnt_d   = HOLD_M1;
                    end else if (sold_out) begin
                        state_d = ERROR;
                        red_d   = E_STOCK;
                        cnt_d   = HOLD_M1;
                    end else if (cred_q < price) begin
                        state_d = ERROR;
                        red_d   = E_FUNDS;
                        cnt_d   = HOLD_M1;
                    end else begin
                        dv_d   = 1'b1;
                        did_d  = select_id;
                        cred_d = remain;
                        if (remain != 4'd0)
                            state_d = CHANGE;
                    end
                end else if (coin_valid) begin
                    if (coin_value == 2'd3 || coin_sum > MAXC) begin
                        cret_d  = 1'b1;
                        state_d = ERROR;
                        red_d   = E_INVAL;
                        cnt_d   = HOLD_M1;
                    end else begin
                        cred_d = coin_sum[3:0];
                    end
                end
            end
            CHANGE: begin
                cret_d  = coin_valid;
                cv_d    = 1'b1;
                chg_d   = cred_q;
                cred_d  = 4'd0;
                state_d = IDLE;
            end
            ERROR: begin
                cret_d = coin_valid;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    red_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                red_d   = 2'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cred_q  <= 4'd0;
            red_q   <= 2'd0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            did_q   <= 2'd0;
            cv_q    <= 1'b0;
            chg_q   <= 4'd0;
            cret_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cred_q  <= cred_d;
            red_q   <= red_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            did_q   <= did_d;
            cv_q    <= cv_d;
            chg_q   <= chg_d;
            cret_q  <= cret_d;
            busy_q  <= busy_d;
        end
    end

    assign credit         = {7'd0, cred_q};
    assign redlight       = red_q;
    assign dispense_valid = dv_q;
    assign dispense_id    = did_q;
    assign change_valid   = cv_q;
    assign change_amount  = {7'd0, chg_q};
    assign coin_return    = cret_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues the expected outputs,
// a negedge monitor pops and compares them one cycle later.
module tb_vend_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin_value = 2'd0;
    logic        select_valid = 1'b0;
    logic [1:0]  select_id = 2'd0;
    logic        cancel = 1'b0;
    logic [2:0]  stock_empty = 3'd0;
    logic [10:0] credit;
    logic [1:0]  redlight;
    logic        dispense_valid;
    logic [1:0]  dispense_id;
    logic        change_valid;
    logic [10:0] change_amount;
    logic        coin_return;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] credit;
        logic [1:0]  red;
        logic        dv;
        logic [1:0]  did;
        logic        cv;
        logic [10:0] ca;
        logic        cr;
        logic        busy;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];

    vend_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .select_valid   (select_valid),
        .select_id      (select_id),
        .cancel         (cancel),
        .stock_empty    (stock_empty),
        .credit         (credit),
        .redlight       (redlight),
        .dispense_valid (dispense_valid),
        .dispense_id    (dispense_id),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .coin_return    (coin_return),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int c, int r, int dv, int did,
                                int cv, int ca, int cr, int bz);
        exp_t e;
        e.credit = 11'(c);
        e.red    = 2'(r);
        e.dv     = 1'(dv);
        e.did    = 2'(did);
        e.cv     = 1'(cv);
        e.ca     = 11'(ca);
        e.cr     = 1'(cr);
        e.busy   = 1'(bz);
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.credit = credit;
        a.red    = redlight;
        a.dv     = dispense_valid;
        a.did    = dispense_id;
        a.cv     = change_valid;
        a.ca     = change_amount;
        a.cr     = coin_return;
        a.busy   = busy;
        return a;
    endfunction

    // monitor: outputs after each rising edge are judged on the falling edge
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = expq.pop_front();
            n = nameq.pop_front();
            a = actual();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got cr=%0d red=%0d dv=%0b id=%0d cv=%0b amt=%0d ret=%0b busy=%0b, expected cr=%0d red=%0d dv=%0b id=%0d cv=%0b amt=%0d ret=%0b busy=%0b",
                         n, a.credit, a.red, a.dv, a.did, a.cv, a.ca, a.cr, a.busy,
                         e.credit, e.red, e.dv, e.did, e.cv, e.ca, e.cr, e.busy);
            end
        end
    end

    task automatic step(input logic cv, input logic [1:0] cval,
                        input logic sv, input logic [1:0] sid,
                        input logic cn, input logic [2:0] se,
                        input logic chk, input exp_t e, input string nm);
        @(negedge clk);
        #2;
        coin_valid   = cv;
        coin_value   = cval;
        select_valid = sv;
        select_id    = sid;
        cancel       = cn;
        stock_empty  = se;
        if (chk) begin
            expq.push_back(e);
            nameq.push_back(nm);
        end
    endtask

    task automatic idle(input exp_t e, input string nm);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, e, nm);
    endtask

    task automatic coin(input logic [1:0] v, input exp_t e, input string nm);
        step(1'b1, v, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, e, nm);
    endtask

    task automatic sel(input logic [1:0] id, input logic [2:0] se,
                       input exp_t e, input string nm);
        step(1'b0, 2'd0, 1'b1, id, 1'b0, se, 1'b1, e, nm);
    endtask

    task automatic cxl(input exp_t e, input string nm);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1, e, nm);
    endtask

    task automatic hold_err(input int c, input int r, input string nm);
        for (int i = 1; i < 8; i++)
            idle(mk(c, r, 0, 0, 0, 0, 0, 1), nm);
        idle(mk(c, 0, 0, 0, 0, 0, 0, 0), {nm, "_end"});
    endtask

    initial begin
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset2");
        rst_n = 1'b1;

        coin(2'd1, mk(2, 0, 0, 0, 0, 0, 0, 0), "a_coin2");
        coin(2'd1, mk(4, 0, 0, 0, 0, 0, 0, 0), "a_coin4");
        coin(2'd0, mk(5, 0, 0, 0, 0, 0, 0, 0), "a_coin5");
        sel(2'd1, 3'd0, mk(0, 0, 1, 1, 0, 0, 0, 0), "a_disp1");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "a_nochg");

        coin(2'd2, mk(5, 0, 0, 0, 0, 0, 0, 0), "b_coin5");
        coin(2'd1, mk(7, 0, 0, 0, 0, 0, 0, 0), "b_coin7");
        sel(2'd0, 3'd0, mk(4, 0, 1, 0, 0, 0, 0, 1), "b_disp0");
        idle(mk(0, 0, 0, 0, 1, 4, 0, 0), "b_change");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "b_idle");

        coin(2'd1, mk(2, 0, 0, 0, 0, 0, 0, 0), "c_coin2");
        sel(2'd2, 3'd0, mk(2, 1, 0, 0, 0, 0, 0, 1), "c_funds");
        idle(mk(2, 1, 0, 0, 0, 0, 0, 1), "c_hold");
        coin(2'd0, mk(2, 1, 0, 0, 0, 0, 1, 1), "c_errcoin");
        for (int i = 3; i < 8; i++)
            idle(mk(2, 1, 0, 0, 0, 0, 0, 1), "c_hold");
        idle(mk(2, 0, 0, 0, 0, 0, 0, 0), "c_clear");
        coin(2'd0, mk(3, 0, 0, 0, 0, 0, 0, 0), "c_accept");
        cxl(mk(3, 0, 0, 0, 0, 0, 0, 1), "c_cancel");
        idle(mk(0, 0, 0, 0, 1, 3, 0, 0), "c_refund");

        coin(2'd2, mk(5, 0, 0, 0, 0, 0, 0, 0), "d_c5");
        coin(2'd2, mk(10, 0, 0, 0, 0, 0, 0, 0), "d_c10");
        coin(2'd1, mk(12, 0, 0, 0, 0, 0, 0, 0), "d_c12");
        coin(2'd1, mk(14, 0, 0, 0, 0, 0, 0, 0), "d_c14");
        coin(2'd1, mk(14, 3, 0, 0, 0, 0, 1, 1), "d_ovf");
        hold_err(14, 3, "d_hold");
        cxl(mk(14, 0, 0, 0, 0, 0, 0, 1), "d_cancel");
        idle(mk(0, 0, 0, 0, 1, 14, 0, 0), "d_refund");

        coin(2'd2, mk(5, 0, 0, 0, 0, 0, 0, 0), "s_c5");
        sel(2'd1, 3'b010, mk(5, 2, 0, 0, 0, 0, 0, 1), "s_empty");
        hold_err(5, 2, "s_hold");
        coin(2'd2, mk(10, 0, 0, 0, 0, 0, 0, 0), "m_c10");
        coin(2'd2, mk(15, 0, 0, 0, 0, 0, 0, 0), "m_max");
        coin(2'd0, mk(15, 3, 0, 0, 0, 0, 1, 1), "m_ovf1");
        hold_err(15, 3, "m_hold");
        cxl(mk(15, 0, 0, 0, 0, 0, 0, 1), "m_cancel");
        idle(mk(0, 0, 0, 0, 1, 15, 0, 0), "m_refund");

        coin(2'd3, mk(0, 3, 0, 0, 0, 0, 1, 1), "i_badcoin");
        hold_err(0, 3, "i_hold");
        sel(2'd3, 3'd0, mk(0, 3, 0, 0, 0, 0, 0, 1), "i_badsel");
        hold_err(0, 3, "i_shold");

        coin(2'd2, mk(5, 0, 0, 0, 0, 0, 0, 0), "e_c5");
        coin(2'd0, mk(6, 0, 0, 0, 0, 0, 0, 0), "e_c6");
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 3'd0, 1'b1,
             mk(6, 0, 0, 0, 0, 0, 1, 1), "e_all");
        idle(mk(0, 0, 0, 0, 1, 6, 0, 0), "e_refund");

        coin(2'd2, mk(5, 0, 0, 0, 0, 0, 0, 0), "r_c5");
        coin(2'd1, mk(7, 0, 0, 0, 0, 0, 0, 0), "r_c7");
        coin(2'd1, mk(9, 0, 0, 0, 0, 0, 0, 0), "r_c9");
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0,
             mk(0, 0, 0, 0, 0, 0, 0, 0), "r_cancel");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (actual() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL r_async: got outputs %h, expected all zero", actual());
        end
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "r_inreset");
        rst_n = 1'b1;
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "r_post");
        coin(2'd0, mk(1, 0, 0, 0, 0, 0, 0, 0), "r_coin1");
        idle(mk(1, 0, 0, 0, 0, 0, 0, 0), "r_idle");

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
